lsu_ram: RTL and testbench

Parametrised byte-addressed data memory for the core's load/store unit, with a valid/ready request channel and a buffered response channel. It supports RV32 LB/LH/LW/LBU/LHU and SB/SH/SW with sign or zero extension, and its depth is configurable. It detects misaligned, out-of-range and illegal accesses. Optionally, it splits word-crossing misaligned accesses into two array beats. It sits between the LSU's address-generation stage and writeback.

---
 rtl/lsu_ram_pkg.sv | 70 +++++++
 rtl/lsu_ram_array.sv | 34 +++
 rtl/lsu_ram.sv | 198 +++++++++++++++++++
 tb/tb_lsu_ram.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ram_pkg.sv
// lsu_ram_pkg: shared definitions for the LSU data memory.
//   - RV32 load/store funct3 encodings
//   - response FSM state type
//   - byte-lane mask, access size and load-extension helpers
//   - misalignment / word-crossing predicates
package lsu_ram_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SPLIT = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Number of bytes touched; 0 marks an undefined encoding.
   function automatic logic [2:0] access_size(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: access_size = 3'd1;
         F3_H, F3_HU: access_size = 3'd2;
         F3_W:        access_size = 3'd4;
         default:     access_size = 3'd0;
      endcase
   endfunction

   // Lane mask for an access starting at lane 0.
   function automatic logic [3:0] lane_mask(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: lane_mask = 4'b0001;
         F3_H, F3_HU: lane_mask = 4'b0011;
         F3_W:        lane_mask = 4'b1111;
         default:     lane_mask = 4'b0000;
      endcase
   endfunction

   // Undefined encodings, and stores using the unsigned-load encodings.
   function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
      funct3_illegal = (access_size(f3) == 3'd0) || (we && f3[2]);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
      case (f3)
         F3_H, F3_HU: is_misaligned = lane[0];
         F3_W:        is_misaligned = (lane != 2'd0);
         default:     is_misaligned = 1'b0;
      endcase
   endfunction

   // True when the last byte of the access lands in the next word.
   function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] lane);
      crosses_word = ({1'b0, lane} + access_size(f3)) > 3'd4;
   endfunction

   // raw holds the addressed bytes starting at bit 0.
   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         F3_B:    extend_load = {{24{raw[7]}}, raw[7:0]};
         F3_H:    extend_load = {{16{raw[15]}}, raw[15:0]};
         F3_BU:   extend_load = {24'd0, raw[7:0]};
         F3_HU:   extend_load = {16'd0, raw[15:0]};
         F3_W:    extend_load = raw;
         default: extend_load = 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ram_array.sv
// lsu_ram_array: word-organised data array with per-byte write strobes.
//   clk    clock
//   en     access this cycle (read, plus write of strobed lanes)
//   be     byte-lane write strobes, bit n = bits [8n+7:8n]
//   idx    word index
//   wdata  lane-positioned write data
//   rdata  registered read data (old contents on a write cycle), held
//          while en is low
// Contents have no reset and are not initialised.
module lsu_ram_array
   import lsu_ram_pkg::*;
#(
   parameter int IDX_W = 10
) (
   input  logic             clk,
   input  logic             en,
   input  logic [3:0]       be,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [2**IDX_W];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[idx];
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/lsu_ram.sv
// lsu_ram: byte-addressed data memory for the load/store unit.
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     request handshake
//   req_we              1 = store, 0 = load
//   req_funct3          RV32 width/sign encoding
//   req_addr            byte address
//   req_wdata           store data, LSB-aligned
//   resp_valid/ready    response handshake, response held until taken
//   resp_rdata          extended load data, 0 for stores and errors
//   resp_err            access fault; nothing written
// Build option LSU_RAM_MISALIGN_SPLIT_EN: misaligned halfword/word accesses
// are serviced (word-crossing ones in two array beats) instead of faulting.
module lsu_ram
   import lsu_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IDX_W = ADDR_WIDTH - 2;

   state_t state_q, state_d;

   logic             accept;
   logic [1:0]       lane;
   logic [IDX_W-1:0] idx;
   logic             out_of_range;
   logic             dec_err;
   logic             need_split;
   logic [3:0]       be_lo;
   logic [31:0]      wd_lo;

   logic             arr_en;
   logic [3:0]       arr_be;
   logic [IDX_W-1:0] arr_idx;
   logic [31:0]      arr_wdata;
   logic [31:0]      arr_rdata;

   logic             err_p1;
   logic             we_p1;
   logic [2:0]       f3_p1;
   logic [1:0]       lane_p1;
   logic [31:0]      raw;

   // Request decode (combinational, acceptance cycle)
   assign lane         = req_addr[1:0];
   assign idx          = req_addr[ADDR_WIDTH-1:2];
   assign out_of_range = |req_addr[31:ADDR_WIDTH];
   assign accept       = req_valid && req_ready;
   assign be_lo        = lane_mask(req_funct3) << lane;
   assign wd_lo        = req_wdata << {lane, 3'b000};

`ifdef LSU_RAM_MISALIGN_SPLIT_EN
   logic             cross;
   logic             last_idx;
   logic [3:0]       be_hi;
   logic [31:0]      wd_hi;
   logic             split_p1;
   logic [IDX_W-1:0] idx_hi_p1;
   logic [3:0]       be_hi_p1;
   logic [31:0]      wd_hi_p1;
   logic [31:0]      lo_word_p2;

   assign cross    = crosses_word(req_funct3, lane);
   // With the first word in range, the second is out of range only when
   // the first is the last word of the array.
   assign last_idx = &idx;
   assign dec_err  = out_of_range || funct3_illegal(req_we, req_funct3) ||
                     (cross && last_idx);
   assign need_split = cross && !dec_err;
   // Bytes that spill past lane 3 land in the low lanes of the next word.
   assign be_hi = lane_mask(req_funct3) >> (3'd4 - {1'b0, lane});
   assign wd_hi = req_wdata >> (6'd32 - {1'b0, lane, 3'b000});
`else
   assign dec_err = out_of_range || funct3_illegal(req_we, req_funct3) ||
                    is_misaligned(req_funct3, lane);
   assign need_split = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         err_p1  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) err_p1 <= dec_err;
      end
   end

   // FSM next state and handshake outputs
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = need_split ? ST_SPLIT : ST_RESP;
         end
`ifdef LSU_RAM_MISALIGN_SPLIT_EN
         ST_SPLIT: begin
            state_d = ST_RESP;
         end
`endif
         ST_RESP: begin
            resp_valid = 1'b1;
            req_ready  = resp_ready;
            if (resp_ready) begin
               if (req_valid) state_d = need_split ? ST_SPLIT : ST_RESP;
               else           state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Array port: first beat at acceptance, second beat from SPLIT.
   // Nothing touches the array while rst is high, so a split store
   // interrupted by reset never writes its second word.
   always_comb begin
      arr_en    = 1'b0;
      arr_be    = 4'b0000;
      arr_idx   = idx;
      arr_wdata = wd_lo;
      if (!rst) begin
         if (accept && !dec_err) begin
            arr_en = 1'b1;
            arr_be = req_we ? be_lo : 4'b0000;
         end
`ifdef LSU_RAM_MISALIGN_SPLIT_EN
         if (state_q == ST_SPLIT) begin
            arr_en    = 1'b1;
            arr_idx   = idx_hi_p1;
            arr_be    = we_p1 ? be_hi_p1 : 4'b0000;
            arr_wdata = wd_hi_p1;
         end
`endif
      end
   end

   lsu_ram_array #(.IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .en    (arr_en),
      .be    (arr_be),
      .idx   (arr_idx),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   // Request attributes held for the response stage
   always_ff @(posedge clk) begin
      if (accept) begin
         we_p1   <= req_we;
         f3_p1   <= req_funct3;
         lane_p1 <= lane;
`ifdef LSU_RAM_MISALIGN_SPLIT_EN
         split_p1  <= need_split;
         idx_hi_p1 <= idx + IDX_W'(1);
         be_hi_p1  <= be_hi;
         wd_hi_p1  <= wd_hi;
`endif
      end
`ifdef LSU_RAM_MISALIGN_SPLIT_EN
      // The first word's read data is overwritten by the second beat.
      if (state_q == ST_SPLIT) lo_word_p2 <= arr_rdata;
`endif
   end

   // Response: align addressed bytes to bit 0, then extend. The array
   // output only changes on a new access, so data holds during a stall.
`ifdef LSU_RAM_MISALIGN_SPLIT_EN
   logic [31:0] lo_src;
   logic [31:0] hi_src;
   assign lo_src = split_p1 ? lo_word_p2 : arr_rdata;
   assign hi_src = split_p1 ? arr_rdata : 32'd0;
   assign raw = (lo_src >> {lane_p1, 3'b000}) |
                (hi_src << (6'd32 - {1'b0, lane_p1, 3'b000}));
`else
   assign raw = arr_rdata >> {lane_p1, 3'b000};
`endif

   assign resp_err   = resp_valid && err_p1;
   assign resp_rdata = (resp_valid && !err_p1 && !we_p1) ? extend_load(f3_p1, raw) : 32'd0;

endmodule

// File: tb/tb_lsu_ram.sv
module tb_lsu_ram;

`ifdef LSU_RAM_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b010;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;

   lsu_ram #(.ADDR_WIDTH(12)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_q[$];
   logic [7:0]  mb [0:4095];

   bit rr_random = 1'b0;
   bit rr_force  = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference model: byte-level memory, rules applied directly.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int sz;
      logic [31:0] v;
      rd = 32'd0;
      er = 1'b0;
      case (f3)
         3'b000, 3'b100: sz = 1;
         3'b001, 3'b101: sz = 2;
         3'b010:         sz = 4;
         default:        sz = 0;
      endcase
      if (sz == 0 || (we && f3[2])) er = 1'b1;
      else if (a >= 32'd4096) er = 1'b1;
      else if ((a % sz) != 0) begin
         if (!SPLIT) er = 1'b1;
         else if (a + sz - 1 >= 32'd4096) er = 1'b1;
      end
      if (er) return;
      if (we) begin
         for (int i = 0; i < sz; i++) mb[a + i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[a + i];
         if (sz == 1)      rd = f3[2] ? v : {{24{v[7]}}, v[7:0]};
         else if (sz == 2) rd = f3[2] ? v : {{16{v[15]}}, v[15:0]};
         else              rd = v;
      end
   endfunction

   // Issue one request; on acceptance push the expected response
   // (model result, or the supplied constants when use_c is set).
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit push, input bit use_c,
                         input logic [31:0] c_rd, input logic c_er, output int waited);
      logic rdy;
      logic [31:0] mrd;
      logic mer;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      waited     = 0;
      do begin
         @(negedge clk);
         rdy = req_ready;
         @(posedge clk);
         waited++;
      end while (!rdy && waited < 50);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", waited);
      end else if (push) begin
         model(we, f3, a, wd, mrd, mer);
         if (use_c) exp_q.push_back({c_er, c_rd});
         else       exp_q.push_back({mer, mrd});
      end
      #1 req_valid = 1'b0;
   endtask

   task automatic req_m(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int w;
      do_req(we, f3, a, wd, 1'b1, 1'b0, 32'd0, 1'b0, w);
   endtask

   task automatic req_c(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic er);
      int w;
      do_req(we, f3, a, wd, 1'b1, 1'b1, rd, er, w);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || resp_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Consumer-side ready
   initial forever begin
      @(posedge clk);
      #1 resp_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_force;
   end

   // Monitor / scoreboard
   logic        stall_prev = 1'b0;
   logic [31:0] rd_prev;
   logic        er_prev;
   initial forever begin
      logic [32:0] e;
      @(negedge clk);
      if (!rst) begin
         if (stall_prev && resp_valid) begin
            chk("hold_rdata", resp_rdata, rd_prev);
            chk("hold_err", {31'd0, resp_err}, {31'd0, er_prev});
         end
         if (resp_valid && !resp_ready) chk("ready_in_stall", {31'd0, req_ready}, 32'd0);
         if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: rdata %h err %b with no request pending", resp_rdata, resp_err);
            end else begin
               e = exp_q.pop_front();
               chk("resp_rdata", resp_rdata, e[31:0]);
               chk("resp_err", {31'd0, resp_err}, {31'd0, e[32]});
            end
         end
      end
      stall_prev = resp_valid && !resp_ready && !rst;
      rd_prev    = resp_rdata;
      er_prev    = resp_err;
   end

   initial begin
      int w;
      int lat;
      logic [31:0] a;
      logic [2:0]  f3;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

      // Known contents for every word the bench reads
      for (int i = 0; i < 'h108; i += 4) req_m(1'b1, 3'b010, i, $urandom);
      for (int i = 'hFF0; i < 'h1000; i += 4) req_m(1'b1, 3'b010, i, $urandom);

      // Directed loads and stores
      req_c(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0);
      req_c(1'b0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0);
      req_c(1'b0, 3'b000, 32'h011, 32'h0, 32'hFFFFFFBE, 1'b0);
      req_c(1'b0, 3'b100, 32'h011, 32'h0, 32'h000000BE, 1'b0);
      req_c(1'b0, 3'b101, 32'h012, 32'h0, 32'h0000DEAD, 1'b0);
      req_c(1'b0, 3'b001, 32'h012, 32'h0, 32'hFFFFDEAD, 1'b0);
      req_c(1'b1, 3'b000, 32'h013, 32'h1234565A, 32'h0, 1'b0);
      req_c(1'b0, 3'b010, 32'h010, 32'h0, 32'h5AADBEEF, 1'b0);
      req_c(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
      req_c(1'b0, 3'b011, 32'h010, 32'h0, 32'h0, 1'b1);
      req_c(1'b1, 3'b100, 32'h010, 32'h11111111, 32'h0, 1'b1);
      req_c(1'b0, 3'b010, 32'h010, 32'h0, 32'h5AADBEEF, 1'b0);
      req_c(1'b0, 3'b010, 32'hFFC, 32'h0, {mb['hFFF], mb['hFFE], mb['hFFD], mb['hFFC]}, 1'b0);
      req_c(1'b0, 3'b001, 32'hFFF, 32'h0, 32'h0, 1'b1);
      req_c(1'b1, 3'b010, 32'hFFE, 32'hCAFEF00D, 32'h0, 1'b1);
      req_m(1'b0, 3'b010, 32'hFFC, 32'h0);

      // Word-crossing load and its latency
      req_c(1'b1, 3'b010, 32'h010, 32'h44332211, 32'h0, 1'b0);
      req_c(1'b1, 3'b010, 32'h014, 32'h88776655, 32'h0, 1'b0);
      drain();
      do_req(1'b0, 3'b010, 32'h012, 32'h0, 1'b1, 1'b1,
             SPLIT ? 32'h66554433 : 32'h0, !SPLIT, w);
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(posedge clk);
         #1 lat++;
      end
      chk("lw012_latency", lat, SPLIT ? 32'd2 : 32'd1);
      drain();
      req_c(1'b0, 3'b101, 32'h011, 32'h0, SPLIT ? 32'h00003322 : 32'h0, !SPLIT);
      req_m(1'b0, 3'b001, 32'h013, 32'h0);
      req_m(1'b1, 3'b001, 32'h017, 32'h0000ABCD);
      req_m(1'b0, 3'b010, 32'h014, 32'h0);
      req_m(1'b0, 3'b010, 32'h018, 32'h0);
      drain();

      // Aligned latency and back-to-back stream
      do_req(1'b0, 3'b010, 32'h020, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, w);
      chk("aligned_resp_valid_T1", {31'd0, resp_valid}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         do_req(1'b0, 3'b010, 32'h040 + 4*i, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, w);
         chk("stream_accept_cycles", w, 32'd1);
      end
      drain();

      // Stall: response must hold, req_ready low
      rr_force = 1'b0;
      @(posedge clk);
      #1;
      req_m(1'b0, 3'b000, 32'h043, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      rr_force = 1'b1;
      @(posedge clk);
      #1;
      drain();

`ifdef LSU_RAM_MISALIGN_SPLIT_EN
      // Reset while the second beat of a split store is pending
      mb['h016] = 8'h0D;
      mb['h017] = 8'hF0;
      do_req(1'b1, 3'b010, 32'h016, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0, w);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("split_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("split_rst_resp_valid_2", {31'd0, resp_valid}, 32'd0);
      req_m(1'b0, 3'b010, 32'h014, 32'h0);
      req_m(1'b0, 3'b010, 32'h018, 32'h0);
      drain();
`endif

      // Randomized traffic with random consumer backpressure
      rr_random = 1'b1;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            8:       a = 32'hFF0 + $urandom_range(0, 15);
            9:       a = 32'h1000 + $urandom_range(0, 32'hFFFF);
            default: a = $urandom_range(0, 255);
         endcase
         f3 = 3'($urandom_range(0, 7));
         req_m(1'($urandom_range(0, 1)), f3, a, $urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rr_random = 1'b0;
      rr_force  = 1'b1;
      @(posedge clk);
      #1;
      drain();
      chk("queue_empty_at_end", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
